sorted_quad_serializer: RTL and testbench

SORTED_QUAD_SERIALIZER -- requirements
Module: sorted_quad_serializer

---
 rtl/sorter_pkg.sv | 45 ++++
 rtl/quad_fifo.sv | 63 ++++++
 rtl/sorted_quad_serializer.sv | 131 +++++++++++++
 tb/tb_sorted_quad_serializer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sorter_pkg.sv
// Shared types and helpers for the sorted-quad serializer: byte width,
// the quad record produced by the upstream 4-element sorter, the FSM
// state encoding, and small pure functions used by the datapath.
package sorter_pkg;

  localparam int BYTE_W = 8;

  // Packed so the quad can live in a single memory word; max is the MSB lane.
  typedef struct packed {
    logic [BYTE_W-1:0] max;
    logic [BYTE_W-1:0] second_max;
    logic [BYTE_W-1:0] second_min;
    logic [BYTE_W-1:0] min;
  } quad_t;

  // IDLE: nothing presented downstream. EMIT: head quad is being serialized.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when the quad is not non-increasing from max down to min.
  // Equal neighbours are a legal sort result and do not count as a violation.
  function automatic logic quad_misordered(input quad_t q);
    return (q.max < q.second_max) ||
           (q.second_max < q.second_min) ||
           (q.second_min < q.min);
  endfunction

  // Select the byte presented at emission position idx. Descending order walks
  // max -> min; ascending order walks the same lanes backwards (3 - idx).
  function automatic logic [BYTE_W-1:0] quad_byte(input quad_t q,
                                                  input logic [1:0] idx,
                                                  input logic ascending);
    logic [1:0] slot;
    slot = ascending ? ~idx : idx;
    case (slot)
      2'd0:    return q.max;
      2'd1:    return q.second_max;
      2'd2:    return q.second_min;
      default: return q.min;
    endcase
  endfunction

endpackage

// File: rtl/quad_fifo.sv
// Circular buffer of sorted quads. Pointers wrap naturally because DEPTH is
// a power of two; an occupancy counter one bit wider than the pointers tells
// full from empty. The head entry is always visible on rdata.
module quad_fifo
  import sorter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  quad_t                    wdata,
  output quad_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  quad_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Write the incoming quad into the tail slot.
  // NOTE: the storage array is deliberately not reset; validity is carried by
  // count and the pointers, and leaving RAM out of reset lets it map to memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Advance pointers and track occupancy; simultaneous push and pop cancel.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The write slot never aliases the head while count < DEPTH, so a push
  // in the same cycle cannot disturb the quad being emitted.
  assign rdata = mem[rd_ptr];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

endmodule

// File: rtl/sorted_quad_serializer.sv
// Buffers sorted quads from a 4-element sorter and emits each one as four
// bytes over a valid/ready stream, largest first (or smallest first when
// ASCENDING=1). Also flags any accepted quad that is not in sort order and
// counts fully emitted quads. DEPTH must be a power of two, at least 2.
module sorted_quad_serializer
  import sorter_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit ASCENDING = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] max,
  input  logic [BYTE_W-1:0] second_max,
  input  logic [BYTE_W-1:0] second_min,
  input  logic [BYTE_W-1:0] min,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              order_err,
  output logic [15:0]       quad_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  quad_t          in_quad;
  quad_t          head;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;

  logic           push;
  logic           pop;
  logic           accept;

  state_t         state_q;
  state_t         state_d;
  logic [1:0]     idx_q;
  logic [1:0]     idx_d;

  assign in_quad = '{max: max, second_max: second_max,
                     second_min: second_min, min: min};

  // in_ready looks only at fullness, never at out_ready, so a full buffer
  // refuses input even in a cycle where the head is about to retire.
  assign in_ready = rst && !fifo_full;
  assign push     = in_valid && in_ready;
  assign accept   = out_valid && out_ready;
  assign pop      = accept && (idx_q == 2'd3);

  quad_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_quad),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Next-state logic: start emitting once a quad is stored, step the byte
  // index on each accepted byte, and roll straight into the next quad.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = EMIT;
          idx_d   = 2'd0;
        end
      end
      EMIT: begin
        if (accept) begin
          if (idx_q == 2'd3) begin
            idx_d = 2'd0;
            // Another quad behind the head (or arriving now) keeps us in
            // EMIT so consecutive quads go out without a bubble.
            if ((fifo_count != CW'(1)) || push) begin
              state_d = EMIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end
    endcase
  end

  // Register FSM state, the emitted-quad counter and the sticky order flag.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      quad_count <= 16'd0;
      order_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pop) begin
        quad_count <= quad_count + 16'd1;
      end
      if (push && quad_misordered(in_quad)) begin
        order_err <= 1'b1;
      end
    end
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign out_valid = rst && (state_q == EMIT);
  assign out_last  = out_valid && (idx_q == 2'd3);
  assign out_data  = out_valid ? quad_byte(head, idx_q, ASCENDING) : '0;

endmodule

// File: tb/tb_sorted_quad_serializer.sv
// Self-checking bench for sorted_quad_serializer. Two instances (descending
// and ascending) share all inputs; a byte-queue reference model predicts
// every output each cycle.
module tb_sorted_quad_serializer;
  import sorter_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  quad_t       in_q;

  logic        in_ready_d, out_valid_d, out_last_d, order_err_d;
  logic [7:0]  out_data_d;
  logic [15:0] quad_count_d;
  logic        in_ready_a, out_valid_a, out_last_a, order_err_a;
  logic [7:0]  out_data_a;
  logic [15:0] quad_count_a;

  int checks = 0;
  int errors = 0;

  // Reference model: pending bytes in emission order for each instance.
  logic [7:0]  dq [$];
  logic [7:0]  aq [$];
  int          occ_prev = 0;
  logic [15:0] exp_count = 16'd0;
  logic        exp_err = 1'b0;

  sorted_quad_serializer #(.DEPTH(DEPTH), .ASCENDING(1'b0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_d),
    .max(in_q.max), .second_max(in_q.second_max),
    .second_min(in_q.second_min), .min(in_q.min),
    .out_data(out_data_d), .out_valid(out_valid_d), .out_ready(out_ready),
    .out_last(out_last_d), .order_err(order_err_d), .quad_count(quad_count_d)
  );

  sorted_quad_serializer #(.DEPTH(DEPTH), .ASCENDING(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .max(in_q.max), .second_max(in_q.second_max),
    .second_min(in_q.second_min), .min(in_q.min),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_last(out_last_a), .order_err(order_err_a), .quad_count(quad_count_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic quad_t mkq(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d);
    return '{max: a, second_max: b, second_min: c, min: d};
  endfunction

  function automatic quad_t rand_quad(input bit sorted);
    logic [7:0] b [$];
    int hi;
    hi = ($urandom_range(0, 3) == 0) ? 3 : 255;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom_range(0, hi)));
    if (sorted) b.rsort();
    return mkq(b[0], b[1], b[2], b[3]);
  endfunction

  // One clock cycle: drive inputs, check all outputs against the model,
  // advance through the edge and update the model.
  task automatic step(input logic iv, input quad_t q, input logic ordy, output logic pushed);
    int         occ;
    logic       ev;
    logic       acc;
    in_valid  = iv;
    in_q      = q;
    out_ready = ordy;
    #1;
    occ = (dq.size() + 3) / 4;
    // A quad is presented once it has been stored for a full cycle; after
    // that, valid stays high until the buffer is drained.
    ev = (occ > 0) && (occ_prev > 0);
    check("in_ready_d", 16'(in_ready_d), 16'(occ < DEPTH));
    check("in_ready_a", 16'(in_ready_a), 16'(occ < DEPTH));
    check("out_valid_d", 16'(out_valid_d), 16'(ev));
    check("out_valid_a", 16'(out_valid_a), 16'(ev));
    check("quad_count_d", quad_count_d, exp_count);
    check("quad_count_a", quad_count_a, exp_count);
    check("order_err_d", 16'(order_err_d), 16'(exp_err));
    check("order_err_a", 16'(order_err_a), 16'(exp_err));
    if (ev) begin
      check("out_data_d", 16'(out_data_d), 16'(dq[0]));
      check("out_data_a", 16'(out_data_a), 16'(aq[0]));
      check("out_last_d", 16'(out_last_d), 16'(dq.size() % 4 == 1));
      check("out_last_a", 16'(out_last_a), 16'(aq.size() % 4 == 1));
    end
    pushed = iv && (occ < DEPTH);
    acc    = ev && ordy;
    @(posedge clk);
    #1;
    occ_prev = occ;
    if (acc) begin
      void'(dq.pop_front());
      void'(aq.pop_front());
      if (dq.size() % 4 == 0) exp_count = exp_count + 16'd1;
    end
    if (pushed) begin
      dq.push_back(q.max);        dq.push_back(q.second_max);
      dq.push_back(q.second_min); dq.push_back(q.min);
      aq.push_back(q.min);        aq.push_back(q.second_min);
      aq.push_back(q.second_max); aq.push_back(q.max);
      if ((q.max < q.second_max) || (q.second_max < q.second_min) ||
          (q.second_min < q.min)) exp_err = 1'b1;
    end
  endtask

  task automatic reset_outputs_quiet(input string tag);
    check({tag, "_in_ready"}, 16'(in_ready_d | in_ready_a), 16'd0);
    check({tag, "_out_valid"}, 16'(out_valid_d | out_valid_a), 16'd0);
    check({tag, "_out_last"}, 16'(out_last_d | out_last_a), 16'd0);
    check({tag, "_out_data"}, 16'(out_data_d | out_data_a), 16'd0);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_q      = '0;
    #1;
    reset_outputs_quiet("rst_hold");
    repeat (n) @(posedge clk);
    #1;
    reset_outputs_quiet("rst_edge");
    dq.delete();
    aq.delete();
    occ_prev  = 0;
    exp_count = 16'd0;
    exp_err   = 1'b0;
    rst       = 1'b1;
  endtask

  task automatic drain();
    logic p;
    for (int i = 0; i < 100 && dq.size() != 0; i++) step(1'b0, '0, 1'b1, p);
    check("drain_timeout", 16'(dq.size()), 16'd0);
    step(1'b0, '0, 1'b1, p);
  endtask

  initial begin
    logic  p;
    int    k;
    quad_t qs [6];

    // Reset state.
    do_reset(2);

    // Single descending quad with out_ready held high; exact cycle timing.
    step(1'b1, mkq(8'h40, 8'h30, 8'h20, 8'h10), 1'b1, p);
    for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, p);
    check("single_quad_count", quad_count_d, 16'd1);
    check("single_quad_err", 16'(order_err_d), 16'd0);

    // All-equal quad must not flag; a misordered one must, and it sticks.
    step(1'b1, mkq(8'h22, 8'h22, 8'h22, 8'h22), 1'b1, p);
    drain();
    check("equal_quad_err", 16'(order_err_d | order_err_a), 16'd0);
    step(1'b1, mkq(8'h10, 8'h20, 8'h05, 8'h01), 1'b1, p);
    drain();
    step(1'b1, mkq(8'h90, 8'h80, 8'h70, 8'h60), 1'b1, p);
    drain();
    check("sticky_err", 16'(order_err_d & order_err_a), 16'd1);

    // Fill with out_ready low: 4 accepted, 5th held off, then full drain.
    do_reset(1);
    for (int i = 0; i < 5; i++) qs[i] = rand_quad(1'b1);
    qs[5] = '0;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step(k < 5, qs[k], 1'b0, p);
      if (p) k++;
    end
    check("fill_accepted", 16'(k), 16'd4);
    for (int i = 0; i < 40 && (k < 5 || dq.size() != 0); i++) begin
      step(k < 5, qs[k], 1'b1, p);
      if (p) k++;
    end
    check("fifth_accepted", 16'(k), 16'd5);
    drain();
    check("fill_count", quad_count_d, 16'd5);

    // Backpressure toggling every cycle while quads stream in.
    do_reset(1);
    for (int i = 0; i < 6; i++) qs[i] = rand_quad(1'b1);
    k = 0;
    for (int i = 0; i < 80; i++) begin
      step(k < 6, qs[k], 1'(i % 2), p);
      if (p) k++;
    end
    drain();
    check("toggle_count", quad_count_d, 16'(k));

    // Reset after the second byte of a quad discards everything.
    do_reset(1);
    step(1'b1, mkq(8'hA4, 8'hA3, 8'hA2, 8'hA1), 1'b1, p);
    for (int i = 0; i < 20 && dq.size() > 2; i++) step(1'b0, '0, 1'b1, p);
    check("mid_quad_bytes_left", 16'(dq.size()), 16'd2);
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, p);
    step(1'b1, mkq(8'h5D, 8'h5C, 8'h5B, 8'h5A), 1'b1, p);
    drain();
    check("post_reset_count", quad_count_d, 16'd1);

    // Randomized traffic, mostly sorted quads with occasional misorders.
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), rand_quad($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 3) != 0), p);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
